// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and defaults for the FIFO-to-stream burst reader.
package fifo_rd_stream_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream, seen from the burst reader (master) and its environment (slave).
interface fifo_rd_stream_if
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              i_rden;
    logic              o_empty;
    logic [DATA_W-1:0] o_rddata;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    modport master (
        output i_rden,
        input  o_empty,
        input  o_rddata,
        output m_valid,
        input  m_ready,
        output m_data
    );

    modport slave (
        input  i_rden,
        output o_empty,
        output o_rddata,
        input  m_valid,
        output m_ready,
        input  m_data
    );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry circular output buffer; head is the oldest word, push and pop may share a cycle.
module fifo_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_pop,
    output logic [1:0]        o_count,
    output logic [DATA_W-1:0] o_head
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // NOTE: the storage is reset too, because the head word drives the stream data bus and must read zero in reset.
    // NOTE: sequential state uses <= so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data_in;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains i_len words from a registered-output FIFO into a valid/ready stream, one word per cycle when unblocked.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [LEN_W-1:0]     i_len,
    fifo_rd_stream_if.master     bus,
    output logic                 busy,
    output logic                 done
);

    state_t            r_state;
    state_t            w_next;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_inflight;

    logic [1:0]        w_count;
    logic [DATA_W-1:0] w_head;
    logic              w_valid;
    logic              w_pop;
    logic              w_rden;
    logic              w_accept;
    logic [2:0]        w_occ;

    assign w_valid  = (w_count != 2'd0);
    assign w_pop    = w_valid && bus.m_ready;
    assign w_accept = (r_state == IDLE) && i_start;

    // Buffer occupancy once this cycle's pop and the in-flight capture have settled.
    assign w_occ = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = (i_len != '0) ? RUN : DONE;
            RUN:     if (w_rden && (r_remaining == LEN_W'(1))) w_next = FLUSH;
            FLUSH:   if (w_occ == 3'd0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_rden = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            RUN: begin
                busy   = 1'b1;
                w_rden = !bus.o_empty && (r_remaining != '0) && (w_occ < 3'd2);
            end
            FLUSH:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_rden;
            if (w_accept) begin
                r_remaining <= i_len;
            end else if (w_rden) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    // A read issued last cycle has its data on o_rddata now; capture it.
    fifo_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .i_push    (r_inflight),
        .i_data_in (bus.o_rddata),
        .i_pop     (w_pop),
        .o_count   (w_count),
        .o_head    (w_head)
    );

    assign bus.i_rden  = w_rden;
    assign bus.m_valid = w_valid;
    assign bus.m_data  = w_head;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomized bursts against a queue-based stream model and a behavioural registered-output FIFO.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          i_start = 1'b0;
    logic [LW-1:0] i_len   = '0;
    logic          busy;
    logic          done;

    fifo_rd_stream_if #(.DATA_W(DW)) bus ();

    fifo_rd_stream #(
        .DATA_W (DW),
        .LEN_W  (LW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_len   (i_len),
        .bus     (bus.master),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: data appears on o_rddata the cycle after a read.
    logic [DW-1:0] mem [1024];
    logic [9:0]    wr_ptr = '0;
    logic [9:0]    rd_ptr = '0;
    logic [DW-1:0] exp_q [$];

    assign bus.o_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.i_rden) begin
            bus.o_rddata <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 10'd1;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int n_rden = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_push(input logic [DW-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 10'd1;
        exp_q.push_back(d);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            step();
            i_start = 1'b0;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'(1));
        if (seen) begin
            step();
            check({tag, "_done_pulse"}, 32'(done), 32'(0));
        end
    endtask

    // Stream scoreboard and safety rules, sampled mid-cycle.
    task automatic monitor();
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] exp_d;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                check("no_underflow", 32'(bus.i_rden & bus.o_empty), 32'(0));
                check("rden_outside_busy", 32'(bus.i_rden & ~busy), 32'(0));
                if (prev_stall) begin
                    check("hold_valid", 32'(bus.m_valid), 32'(1));
                    check("hold_data", 32'(bus.m_data), 32'(prev_data));
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_word", 32'(bus.m_valid), 32'(0));
                    end else begin
                        exp_d = exp_q.pop_front();
                        check("stream_order", 32'(bus.m_data), 32'(exp_d));
                    end
                end
                if (bus.i_rden) n_rden++;
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
            end
        end
    endtask

    initial begin
        int base;
        bus.m_ready = 1'b0;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) step();
        check("rst_rden", 32'(bus.i_rden), 32'(0));
        check("rst_valid", 32'(bus.m_valid), 32'(0));
        check("rst_data", 32'(bus.m_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_done", 32'(done), 32'(0));

        // Burst of 4 from a preloaded FIFO at full rate
        for (int k = 0; k < 4; k++) fifo_push(DW'(32'h11 + k));
        bus.m_ready = 1'b1;
        i_len   = LW'(4);
        i_start = 1'b1;
        base    = n_rden;
        for (int c = 1; c <= 8; c++) begin
            step();
            i_start = 1'b0;
            check("a_rden", 32'(bus.i_rden), 32'(c <= 4));
            check("a_valid", 32'(bus.m_valid), 32'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check("a_data", 32'(bus.m_data), 32'(32'h11 + c - 3));
            check("a_busy", 32'(busy), 32'(c <= 6));
            check("a_done", 32'(done), 32'(c == 7));
        end
        check("a_reads", 32'(n_rden - base), 32'(4));

        // Zero-length burst: no reads, immediate done
        fifo_push(DW'($urandom));
        fifo_push(DW'($urandom));
        i_len   = '0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("b_done", 32'(done), 32'(1));
        check("b_busy", 32'(busy), 32'(0));
        check("b_rden", 32'(bus.i_rden), 32'(0));
        step();
        check("b_done_end", 32'(done), 32'(0));
        check("b_busy_end", 32'(busy), 32'(0));
        check("b_fifo_untouched", 32'(wr_ptr - rd_ptr), 32'(2));

        // Burst of 6 with a 5-cycle downstream stall
        for (int k = 0; k < 4; k++) fifo_push(DW'($urandom));
        i_len   = LW'(6);
        i_start = 1'b1;
        base    = n_rden;
        step();
        i_start = 1'b0;
        step();
        step();
        bus.m_ready = 1'b0;
        step();
        step();
        check("c_stall_rden", 32'(bus.i_rden), 32'(0));
        check("c_stall_valid", 32'(bus.m_valid), 32'(1));
        step();
        step();
        check("c_stall_rden_late", 32'(bus.i_rden), 32'(0));
        check("c_stall_busy", 32'(busy), 32'(1));
        step();
        bus.m_ready = 1'b1;
        wait_done("c", 60);
        check("c_reads", 32'(n_rden - base), 32'(6));
        check("c_all_out", 32'(exp_q.size()), 32'(0));

        // Burst of 3 with the FIFO running dry mid-burst
        fifo_push(DW'($urandom));
        i_len   = LW'(3);
        i_start = 1'b1;
        base    = n_rden;
        step();
        i_start = 1'b0;
        step();
        step();
        check("d_wait_busy", 32'(busy), 32'(1));
        check("d_wait_rden", 32'(bus.i_rden), 32'(0));
        step();
        check("d_wait_busy2", 32'(busy), 32'(1));
        step();
        fifo_push(DW'($urandom));
        step();
        step();
        step();
        fifo_push(DW'($urandom));
        wait_done("d", 40);
        check("d_reads", 32'(n_rden - base), 32'(3));
        check("d_all_out", 32'(exp_q.size()), 32'(0));

        // Start pulse while busy must not reload the length
        for (int k = 0; k < 7; k++) fifo_push(DW'($urandom));
        i_len   = LW'(5);
        i_start = 1'b1;
        base    = n_rden;
        step();
        i_start = 1'b0;
        step();
        i_start = 1'b1;
        i_len   = LW'(2);
        step();
        i_start = 1'b0;
        wait_done("e", 40);
        check("e_reads", 32'(n_rden - base), 32'(5));
        check("e_fifo_left", 32'(wr_ptr - rd_ptr), 32'(2));

        // Reset while the buffer is full; buffered words are lost
        bus.m_ready = 1'b0;
        i_len   = LW'(6);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (5) step();
        check("f_pre_valid", 32'(bus.m_valid), 32'(1));
        check("f_pre_rden", 32'(bus.i_rden), 32'(0));
        check("f_pre_busy", 32'(busy), 32'(1));
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("f_rst_valid", 32'(bus.m_valid), 32'(0));
        check("f_rst_rden", 32'(bus.i_rden), 32'(0));
        check("f_rst_data", 32'(bus.m_data), 32'(0));
        check("f_rst_busy", 32'(busy), 32'(0));
        step();
        rst = 1'b0;
        step();
        check("f_post_busy", 32'(busy), 32'(0));
        check("f_post_valid", 32'(bus.m_valid), 32'(0));
        for (int k = 0; k < 3; k++) fifo_push(DW'($urandom));
        bus.m_ready = 1'b1;
        i_len   = LW'(3);
        i_start = 1'b1;
        base    = n_rden;
        wait_done("f", 40);
        check("f_reads", 32'(n_rden - base), 32'(3));
        check("f_all_out", 32'(exp_q.size()), 32'(0));

        // Randomized bursts: random lengths, late FIFO fill, random backpressure, stray starts
        for (int b = 0; b < 15; b++) begin
            int len;
            int avail;
            int to_write;
            int pre;
            int written;
            bit seen;
            len      = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            avail    = int'(wr_ptr - rd_ptr);
            to_write = (len > avail) ? len - avail : 0;
            pre      = int'($urandom_range(0, to_write));
            for (int k = 0; k < pre; k++) fifo_push(DW'($urandom));
            written  = pre;
            seen     = 1'b0;
            i_len    = LW'(len);
            i_start  = 1'b1;
            base     = n_rden;
            for (int c = 0; c < 300 && !seen; c++) begin
                step();
                i_start     = 1'b0;
                bus.m_ready = ($urandom_range(0, 3) != 0);
                if (written < to_write && $urandom_range(0, 1) == 1) begin
                    fifo_push(DW'($urandom));
                    written++;
                end
                if (done) begin
                    seen = 1'b1;
                end else if (busy && $urandom_range(0, 7) == 0) begin
                    i_start = 1'b1;
                    i_len   = LW'($urandom_range(0, 12));
                end
            end
            check("g_done_seen", 32'(seen), 32'(1));
            check("g_reads", 32'(n_rden - base), 32'(len));
            step();
            i_start = 1'b0;
            check("g_done_pulse", 32'(done), 32'(0));
        end
        bus.m_ready = 1'b1;
        repeat (4) step();
        check("final_all_out", 32'(exp_q.size()), 32'(wr_ptr - rd_ptr));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
